// File: rtl/muldiv_issue_pkg.sv
// rtl/muldiv_issue_pkg.sv - shared funct3 codes, FSM states and operand-sign helpers for the M-op issue logic.
package muldiv_issue_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LAUNCH = 3'd1,
      ST_WAIT   = 3'd2,
      ST_DONE   = 3'd3,
      ST_DRAIN  = 3'd4
   } state_t;

   localparam logic [2:0] F3_MUL    = 3'd0;
   localparam logic [2:0] F3_MULH   = 3'd1;
   localparam logic [2:0] F3_MULHSU = 3'd2;
   localparam logic [2:0] F3_MULHU  = 3'd3;
   localparam logic [2:0] F3_DIV    = 3'd4;
   localparam logic [2:0] F3_DIVU   = 3'd5;
   localparam logic [2:0] F3_REM    = 3'd6;
   localparam logic [2:0] F3_REMU   = 3'd7;

   localparam logic [31:0] INT_MIN = 32'h8000_0000;

   function automatic logic signed_a(input logic [2:0] f3);
      return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

   function automatic logic signed_b(input logic [2:0] f3);
      return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

endpackage

// File: rtl/muldiv_fixup.sv
// rtl/muldiv_fixup.sv - restores signs on the raw unsigned unit output and selects the 32-bit rd value.
module muldiv_fixup
   import muldiv_issue_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic        neg_a,
   input  logic        neg_b,
   input  logic [63:0] raw,
   output logic [31:0] result
);

   logic [63:0] prod;
   logic [31:0] quot;
   logic [31:0] rem;

   // Quotient sign follows both operands; remainder sign follows the dividend.
   always_comb begin
      prod = (neg_a ^ neg_b) ? (~raw + 64'd1) : raw;
      quot = (neg_a ^ neg_b) ? (~raw[31:0] + 32'd1) : raw[31:0];
      rem  = neg_a ? (~raw[63:32] + 32'd1) : raw[63:32];
      case (funct3)
         F3_MUL:                       result = prod[31:0];
         F3_MULH, F3_MULHSU, F3_MULHU: result = prod[63:32];
         F3_DIV, F3_DIVU:              result = quot;
         default:                      result = rem;
      endcase
   end

endmodule

// File: rtl/muldiv_issue.sv
// rtl/muldiv_issue.sv - EX-stage requester for the multDiv unit: launch, stall, sign fixup, corner cases.
// Optional MULDIV_RESULT_CACHE_EN keeps the last completed {mode, |A|, |B|, md_out} to skip repeat launches.
module muldiv_issue
   import muldiv_issue_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int MD_LATENCY = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              op_valid,
   input  logic [2:0]        op_funct3,
   input  logic [XLEN-1:0]   op_a,
   input  logic [XLEN-1:0]   op_b,
   input  logic              op_kill,
   output logic              stall,
   output logic [XLEN-1:0]   result,
   output logic              result_valid,
   output logic              md_valid,
   output logic              md_mode,
   output logic [XLEN-1:0]   md_a,
   output logic [XLEN-1:0]   md_b,
   input  logic              md_ready,
   input  logic [2*XLEN-1:0] md_out
);

   state_t            state_q, state_d;
   logic [2:0]        f3_q;
   logic              neg_a_q, neg_b_q, mode_q;
   logic [XLEN-1:0]   mag_a_q, mag_b_q;
   logic [2*XLEN-1:0] raw_q;
   logic              special_q;
   logic [XLEN-1:0]   special_val_q;
   logic [7:0]        wait_cnt_q;

   logic              neg_a_c, neg_b_c, mode_c;
   logic [XLEN-1:0]   mag_a_c, mag_b_c;
   logic              special_c;
   logic [XLEN-1:0]   special_val_c;
   logic              hit_c;
   logic [2*XLEN-1:0] hit_out;
   logic              accept;
   logic [XLEN-1:0]   fix_result;

   always_comb begin
      neg_a_c       = op_a[XLEN-1] & signed_a(op_funct3);
      neg_b_c       = op_b[XLEN-1] & signed_b(op_funct3);
      mag_a_c       = neg_a_c ? (~op_a + 32'd1) : op_a;
      mag_b_c       = neg_b_c ? (~op_b + 32'd1) : op_b;
      mode_c        = op_funct3[2];
      special_c     = 1'b0;
      special_val_c = '0;
      // funct3[1] separates the REM family from the DIV family.
      if (mode_c && (op_b == '0)) begin
         special_c     = 1'b1;
         special_val_c = op_funct3[1] ? op_a : '1;
      end else if (((op_funct3 == F3_DIV) || (op_funct3 == F3_REM)) &&
                   (op_a == INT_MIN) && (op_b == '1)) begin
         special_c     = 1'b1;
         special_val_c = op_funct3[1] ? '0 : INT_MIN;
      end
   end

   assign accept = (state_q == ST_IDLE) && op_valid && !op_kill;

`ifdef MULDIV_RESULT_CACHE_EN
   logic              cache_valid_q;
   logic              cache_mode_q;
   logic [XLEN-1:0]   cache_a_q, cache_b_q;
   logic [2*XLEN-1:0] cache_out_q;

   assign hit_c   = cache_valid_q && (cache_mode_q == mode_c) &&
                    (cache_a_q == mag_a_c) && (cache_b_q == mag_b_c);
   assign hit_out = cache_out_q;

   // A kill coinciding with md_ready counts as drained, so it never fills the cache.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cache_valid_q <= 1'b0;
         cache_mode_q  <= 1'b0;
         cache_a_q     <= '0;
         cache_b_q     <= '0;
         cache_out_q   <= '0;
      end else if ((state_q == ST_WAIT) && md_ready && !op_kill) begin
         cache_valid_q <= 1'b1;
         cache_mode_q  <= mode_q;
         cache_a_q     <= mag_a_q;
         cache_b_q     <= mag_b_q;
         cache_out_q   <= md_out;
      end
   end
`else
   assign hit_c   = 1'b0;
   assign hit_out = '0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (accept) state_d = (special_c || hit_c) ? ST_DONE : ST_LAUNCH;
         ST_LAUNCH: state_d = op_kill ? ST_DRAIN : ST_WAIT;
         ST_WAIT: begin
            if (md_ready)     state_d = op_kill ? ST_IDLE : ST_DONE;
            else if (op_kill) state_d = ST_DRAIN;
         end
         ST_DONE:   state_d = ST_IDLE;
         ST_DRAIN:  if (md_ready) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f3_q          <= '0;
         neg_a_q       <= 1'b0;
         neg_b_q       <= 1'b0;
         mode_q        <= 1'b0;
         mag_a_q       <= '0;
         mag_b_q       <= '0;
         raw_q         <= '0;
         special_q     <= 1'b0;
         special_val_q <= '0;
      end else if (accept) begin
         f3_q          <= op_funct3;
         neg_a_q       <= neg_a_c;
         neg_b_q       <= neg_b_c;
         mode_q        <= mode_c;
         mag_a_q       <= mag_a_c;
         mag_b_q       <= mag_b_c;
         raw_q         <= hit_out;
         special_q     <= special_c;
         special_val_q <= special_val_c;
      end else if ((state_q == ST_WAIT) && md_ready) begin
         raw_q <= md_out;
      end
   end

   muldiv_fixup u_fixup (
      .funct3 (f3_q),
      .neg_a  (neg_a_q),
      .neg_b  (neg_b_q),
      .raw    (raw_q),
      .result (fix_result)
   );

   always_comb begin
      md_valid     = (state_q == ST_LAUNCH);
      md_mode      = md_valid ? mode_q  : 1'b0;
      md_a         = md_valid ? mag_a_q : '0;
      md_b         = md_valid ? mag_b_q : '0;
      result_valid = (state_q == ST_DONE) && !op_kill;
      result       = result_valid ? (special_q ? special_val_q : fix_result) : '0;
      stall        = rst_n && op_valid && !result_valid;
   end

   // Watchdog on the unit handshake, bounded well above its nominal latency.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                    wait_cnt_q <= '0;
      else if (state_q != ST_WAIT)   wait_cnt_q <= '0;
      else if (wait_cnt_q != 8'hFF)  wait_cnt_q <= wait_cnt_q + 8'd1;
   end

   a_wait_bound: assert property (@(posedge clk) disable iff (!rst_n)
      (state_q == ST_WAIT) |-> (int'(wait_cnt_q) <= 2 * MD_LATENCY + 4));

endmodule

// File: tb/tb_muldiv_issue.sv
// tb/tb_muldiv_issue.sv - directed self-checking bench for muldiv_issue with a behavioural multDiv unit.
module tb_muldiv_issue;

`ifdef MULDIV_RESULT_CACHE_EN
   localparam int HIT_LAT = 1;
   localparam int HIT_LAUNCH = 0;
`else
   localparam int HIT_LAT = 35;
   localparam int HIT_LAUNCH = 1;
`endif

   logic        clk;
   logic        rst_n;
   logic        op_valid;
   logic [2:0]  op_funct3;
   logic [31:0] op_a, op_b;
   logic        op_kill;
   logic        stall;
   logic [31:0] result;
   logic        result_valid;
   logic        md_valid;
   logic        md_mode;
   logic [31:0] md_a, md_b;
   logic        md_ready;
   logic [63:0] md_out;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int md_cnt = 0;
   int launches = 0;
   int relaunch = 0;
   logic [63:0] md_res;

   muldiv_issue #(.XLEN(32), .MD_LATENCY(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .op_valid     (op_valid),
      .op_funct3    (op_funct3),
      .op_a         (op_a),
      .op_b         (op_b),
      .op_kill      (op_kill),
      .stall        (stall),
      .result       (result),
      .result_valid (result_valid),
      .md_valid     (md_valid),
      .md_mode      (md_mode),
      .md_a         (md_a),
      .md_b         (md_b),
      .md_ready     (md_ready),
      .md_out       (md_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Unit model: md_ready pulses 33 cycles after the launch cycle.
   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         md_cnt   = 0;
         md_ready = 1'b0;
         md_out   = '0;
      end else begin
         if (md_ready) begin
            md_ready = 1'b0;
            md_out   = '0;
         end
         if (md_cnt > 0) begin
            md_cnt--;
            if (md_cnt == 0) begin
               md_ready = 1'b1;
               md_out   = md_res;
            end
         end
         if (md_valid) begin
            launches++;
            if (md_cnt != 0) relaunch++;
            md_cnt = 33;
            if (!md_mode)       md_res = {32'd0, md_a} * {32'd0, md_b};
            else if (md_b == 0) md_res = {md_a, 32'hFFFF_FFFF};
            else                md_res = {md_a % md_b, md_a / md_b};
         end
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic present(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          output int start, output int l0);
      @(negedge clk);
      op_valid  = 1'b1;
      op_funct3 = f3;
      op_a      = a;
      op_b      = b;
      start     = cyc;
      l0        = launches;
   endtask

   task automatic await_result(input string tag, input logic [31:0] exp, input int start,
                               input int exp_lat, input int l0, input int exp_launch);
      bit seen;
      int lat;
      seen = 1'b0;
      lat  = -1;
      for (int i = 0; i < 120; i++) begin
         @(negedge clk);
         if (result_valid) begin
            seen = 1'b1;
            lat  = cyc - start;
            break;
         end
         if (i == 0) check_eq({tag, "_stall"}, stall, 1'b1);
      end
      check_eq({tag, "_seen"}, seen, 1'b1);
      check_eq({tag, "_lat"}, lat, exp_lat);
      check_eq({tag, "_res"}, result, exp);
      check_eq({tag, "_nostall"}, stall, 1'b0);
      check_eq({tag, "_launch"}, launches - l0, exp_launch);
      op_valid = 1'b0;
   endtask

   task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                         input int exp_launch);
      int s, l0;
      present(f3, a, b, s, l0);
      await_result(tag, exp, s, exp_lat, l0, exp_launch);
   endtask

   initial begin
      int s, l0;
      rst_n     = 1'b0;
      op_valid  = 1'b1;
      op_funct3 = 3'd0;
      op_a      = '0;
      op_b      = '0;
      op_kill   = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("reset_outs", {stall, result_valid, md_valid, md_mode, result, md_a, md_b}, '0);
      op_valid = 1'b0;
      rst_n    = 1'b1;
      @(negedge clk);
      check_eq("idle_md", {md_valid, md_mode, md_a, md_b, stall}, '0);

      run_op("mul",    3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 35, 1);
      run_op("mulh",   3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 35, 1);
      run_op("mulhsu", 3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 35, 1);
      run_op("mulhu",  3'd3, 32'hFFFF_FFFF,  32'd2,         32'h0000_0001, 35, 1);
      run_op("div",    3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 35, 1);
      run_op("rem",    3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, HIT_LAT, HIT_LAUNCH);
      run_op("divu",   3'd5, 32'hFFFF_FFF9,  32'd2,         32'h7FFF_FFFC, 35, 1);
      run_op("div0",   3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1, 0);
      run_op("remu0",  3'd7, 32'd5,          32'd0,         32'd5,         1, 0);
      run_op("divovf", 3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
      run_op("div100", 3'd4, 32'd100,        32'd7,         32'd14,        35, 1);
      run_op("rem100", 3'd6, 32'd100,        32'd7,         32'd2,         HIT_LAT, HIT_LAUNCH);

      // Flush mid-WAIT; the replacement op must wait for the abandoned md_ready.
      present(3'd5, 32'd1000, 32'd10, s, l0);
      while (cyc < s + 10) @(negedge clk);
      op_kill = 1'b1;
      check_eq("kill_rv", result_valid, 1'b0);
      @(negedge clk);
      op_kill   = 1'b0;
      op_funct3 = 3'd0;
      op_a      = 32'd3;
      op_b      = 32'd4;
      await_result("kill_mul", 32'd12, s, 70, l0, 2);

      // Asynchronous reset while the unit is busy.
      present(3'd0, 32'd5, 32'd6, s, l0);
      while (cyc < s + 10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_eq("rst_wait_outs", {stall, result_valid, md_valid, md_mode, result, md_a, md_b}, '0);
      op_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      run_op("post_rst", 3'd3, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 35, 1);

      check_eq("relaunch", relaunch, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
